packed_macc_unpack: RTL and testbench

PACKED_MACC_UNPACK -- requirements
Module: packed_macc_unpack

---
 rtl/packed_macc_unpack_if.sv | 29 ++
 rtl/packed_macc_unpack.sv | 78 +++++++
 tb/tb_packed_macc_unpack.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/packed_macc_unpack_if.sv
// Handshake bundle for packed_macc_unpack: packed DSP words in, corrected (ji, ki) pairs out.
// out_count exists only when UNPACK_STATS_EN is defined.
interface packed_macc_unpack_if #(
    parameter int WIDTH = 8
);
    localparam int KW = 24 - WIDTH;
    localparam int JW = 24 + WIDTH;

    logic                 in_valid;
    logic                 in_ready;
    logic [47:0]          in_p;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [JW-1:0] out_ji;
    logic signed [KW-1:0] out_ki;
`ifdef UNPACK_STATS_EN
    logic [15:0]          out_count;

    modport master (output in_valid, in_p, out_ready,
                    input  in_ready, out_valid, out_ji, out_ki, out_count);
    modport slave  (input  in_valid, in_p, out_ready,
                    output in_ready, out_valid, out_ji, out_ki, out_count);
`else
    modport master (output in_valid, in_p, out_ready,
                    input  in_ready, out_valid, out_ji, out_ki);
    modport slave  (input  in_valid, in_p, out_ready,
                    output in_ready, out_valid, out_ji, out_ki);
`endif
endinterface

// File: rtl/packed_macc_unpack.sv
// Unpacks a two-product packed MACC word into signed (ji, ki), restoring the borrow a negative
// low field takes from the high field. One register stage, credit-guarded FIFO. Option: UNPACK_STATS_EN.
module packed_macc_unpack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    packed_macc_unpack_if.slave  bus
);
    localparam int KW = 24 - WIDTH;
    localparam int JW = 24 + WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [JW-1:0] ji;
        logic [KW-1:0] ki;
    } res_t;

    logic          live;
    logic          s1_vld;
    logic [47:0]   s1_p;
    logic [CW-1:0] inflight;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          out_vld, in_xfer, out_xfer;
    res_t          s1_res;
    res_t          mem [DEPTH];

    // Credits cover S1 plus the FIFO, so an S1 flush always finds a free slot.
    assign bus.in_ready = live && (inflight < CW'(DEPTH));
    assign out_vld      = (inflight != CW'(s1_vld));
    assign bus.out_valid = out_vld;
    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = out_vld && bus.out_ready;

    assign s1_res.ki = s1_p[KW-1:0];
    assign s1_res.ji = s1_p[47:KW] + JW'(s1_p[KW-1]);

    assign bus.out_ji = out_vld ? mem[rd_ptr].ji : '0;
    assign bus.out_ki = out_vld ? mem[rd_ptr].ki : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= 1'b0;
            s1_vld   <= 1'b0;
            s1_p     <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            live   <= 1'b1;
            s1_vld <= in_xfer;
            if (in_xfer) s1_p <= bus.in_p;
            if (s1_vld) wr_ptr <= wr_ptr + AW'(1);
            if (out_xfer) rd_ptr <= rd_ptr + AW'(1);
            case ({in_xfer, out_xfer})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (s1_vld) mem[wr_ptr] <= s1_res;
    end

`ifdef UNPACK_STATS_EN
    logic [15:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        count <= '0;
        else if (out_xfer) count <= count + 16'd1;
    end
    assign bus.out_count = count;
`endif
endmodule

// File: tb/tb_packed_macc_unpack.sv
// Directed + random check of packed_macc_unpack (WIDTH=8, DEPTH=4) with an in-order scoreboard.
module tb_packed_macc_unpack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] ji;
        logic [15:0] ki;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    bit   rnd = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    packed_macc_unpack_if #(.WIDTH(WIDTH)) bus ();
    packed_macc_unpack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [47:0] p);
        exp_t e;
        e.ki = p[15:0];
        e.ji = p[47:16] + {31'd0, p[15]};
        return e;
    endfunction

    // One clock: scoreboard push/pop at the falling edge, then return just after the rising edge.
    task automatic tick(output bit acc);
        exp_t e;
        acc = 1'b0;
        @(negedge clk);
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_p));
                acc = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", {16'd0, bus.out_ji}, 48'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_ji", {16'd0, bus.out_ji}, {16'd0, e.ji});
                    chk("sb_ki", {32'd0, bus.out_ki}, {32'd0, e.ki});
                    n_pop++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [47:0] p);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_p = p;
        for (int i = 0; i < 200 && !acc; i++) tick(acc);
        if (!acc) chk("send_timeout", 48'd0, 48'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        rnd = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && q.size() != 0; i++) tick(acc);
        chk("drain_empty", 48'(q.size()), 48'd0);
    endtask

    task automatic fill(output int k);
        bit acc;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        k = 0;
        bus.in_p = 48'h1111_0000_0000 + 48'h0000_0001_8000;
        for (int i = 0; i < 12; i++) begin
            tick(acc);
            if (acc) k++;
            bus.in_p = 48'h1111_0000_0000 + 48'(k) * 48'h0000_0001_7FFF;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        int k;
        int base;
        logic [63:0] r;

        bus.in_valid = 1'b0;
        bus.in_p = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", {47'd0, bus.out_valid}, 48'd0);
        chk("rst_in_ready", {47'd0, bus.in_ready}, 48'd0);
        chk("rst_out_ji", {16'd0, bus.out_ji}, 48'd0);
        chk("rst_out_ki", {32'd0, bus.out_ki}, 48'd0);
`ifdef UNPACK_STATS_EN
        chk("rst_count", {32'd0, bus.out_count}, 48'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("in_ready_pre_edge", {47'd0, bus.in_ready}, 48'd0);
        tick(acc);
        chk("in_ready_post_edge", {47'd0, bus.in_ready}, 48'd1);

        // Latency and borrow correction: hi=152, lo=-58
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_p = 48'h0000_0098_FFC6;
        tick(acc);
        bus.in_valid = 1'b0;
        chk("lat_accept", {47'd0, acc}, 48'd1);
        chk("lat_not_yet", {47'd0, bus.out_valid}, 48'd0);
        tick(acc);
        chk("lat_valid", {47'd0, bus.out_valid}, 48'd1);
        chk("lat_ji", {16'd0, bus.out_ji}, 48'd153);
        chk("lat_ki", {32'd0, bus.out_ki}, 48'h0000_0000_FFC6);

        // Positive low field: no correction
        send({32'd3, 16'd2});
        tick(acc);
        chk("pos_ji", {16'd0, bus.out_ji}, 48'd3);
        chk("pos_ki", {32'd0, bus.out_ki}, 48'd2);

        // High field wrap
        send({32'h7FFF_FFFF, 16'h8000});
        tick(acc);
        chk("wrap_ji", {16'd0, bus.out_ji}, 48'h0000_8000_0000);
        chk("wrap_ki", {32'd0, bus.out_ki}, 48'h0000_0000_8000);
        drain();

        // Backpressure: exactly DEPTH accepted, then drained in order
        fill(k);
        chk("full_accepted", 48'(k), 48'(DEPTH));
        chk("full_in_ready", {47'd0, bus.in_ready}, 48'd0);
        drain();

        // Reset while full discards everything
        fill(k);
        chk("full2_accepted", 48'(k), 48'(DEPTH));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {47'd0, bus.out_valid}, 48'd0);
        chk("midrst_in_ready", {47'd0, bus.in_ready}, 48'd0);
        q.delete();
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick(acc);
        chk("postrst_in_ready", {47'd0, bus.in_ready}, 48'd1);
        chk("postrst_out_valid", {47'd0, bus.out_valid}, 48'd0);
`ifdef UNPACK_STATS_EN
        chk("postrst_count", {32'd0, bus.out_count}, 48'd0);
`endif

        // Random stream with random consumer stalls
        base = n_pop;
        rnd = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r = {$urandom, $urandom};
            send(r[47:0]);
        end
        drain();
        for (int i = 0; i < 4; i++) tick(acc);
        chk("rand_delivered", 48'(n_pop - base), 48'd100);
        chk("rand_idle", {47'd0, bus.out_valid}, 48'd0);
`ifdef UNPACK_STATS_EN
        chk("rand_count", {32'd0, bus.out_count}, 48'd100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
